// File: rtl/polyphase_input_commutator.sv
// polyphase_input_commutator: steers serial samples round-robin (M-1 down to 0) onto polyphase branches.
// Optional COMMUTATOR_RESYNC_EN adds i_sync to restart the rotation at branch M-1.
module polyphase_input_commutator #(
    parameter int gp_data_width    = 8,
    parameter int gp_nr_phases     = 4,
    parameter int gp_nr_taps_phase = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    input  logic [gp_data_width-1:0]        i_data,
`ifdef COMMUTATOR_RESYNC_EN
    input  logic                            i_sync,
`endif
    output logic [gp_data_width-1:0]        o_branch_data,
    output logic [gp_nr_phases-1:0]         o_branch_ena,
    output logic [$clog2(gp_nr_phases)-1:0] o_phase,
    output logic                            o_frame_valid,
    output logic                            o_primed
);
    localparam int PW = $clog2(gp_nr_phases);
    localparam int CW = $clog2(gp_nr_taps_phase + 1);
    localparam logic [PW-1:0] last_phase = PW'(gp_nr_phases - 1);
    localparam logic [CW-1:0] taps_max = CW'(gp_nr_taps_phase);
    localparam logic [gp_nr_phases-1:0] one = {{(gp_nr_phases-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, sel;
    logic [CW-1:0] frames, frames_nx;
    logic          sync, frame_done;

`ifdef COMMUTATOR_RESYNC_EN
    assign sync = i_valid & i_sync;
`else
    assign sync = 1'b0;
`endif

    // A resync sample restarts the rotation as if it were the first sample after reset.
    always_comb begin
        sel        = sync ? last_phase : phase;
        frame_done = i_valid && !sync && phase == '0;
        frames_nx  = sync ? '0 : (frame_done && frames != taps_max) ? frames + 1'b1 : frames;
        state_nx   = sync ? LOAD
                   : (frame_done && frames_nx == taps_max) ? RUN
                   : (state == IDLE && i_valid) ? LOAD
                   : state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_branch_data <= '0;
            o_branch_ena  <= '0;
            o_frame_valid <= 1'b0;
            phase         <= last_phase;
            frames        <= '0;
            state         <= IDLE;
        end else begin
            o_branch_ena  <= i_valid ? one << sel : '0;
            o_frame_valid <= frame_done;
            frames        <= frames_nx;
            state         <= state_nx;
            if (i_valid) begin
                o_branch_data <= i_data;
                phase         <= (sel == '0) ? last_phase : sel - 1'b1;
            end
        end
    end

    assign o_phase  = phase;
    assign o_primed = state == RUN;
endmodule

// File: tb/tb_polyphase_input_commutator.sv
// tb_polyphase_input_commutator: scoreboard bench for M=4 (and an M=3 instance); define COMMUTATOR_RESYNC_EN to cover i_sync.
module tb_polyphase_input_commutator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, fv, primed;
    logic [7:0] data, bdata;
    logic [3:0] ena;
    logic [1:0] phase;
    logic       valid3, fv3, primed3;
    logic [7:0] data3, bdata3;
    logic [2:0] ena3;
    logic [1:0] phase3;
`ifdef COMMUTATOR_RESYNC_EN
    logic sync;
`endif

    polyphase_input_commutator #(.gp_data_width(8), .gp_nr_phases(4), .gp_nr_taps_phase(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
`ifdef COMMUTATOR_RESYNC_EN
        .i_sync(sync),
`endif
        .o_branch_data(bdata), .o_branch_ena(ena), .o_phase(phase),
        .o_frame_valid(fv), .o_primed(primed)
    );

    polyphase_input_commutator #(.gp_data_width(8), .gp_nr_phases(3), .gp_nr_taps_phase(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid3), .i_data(data3),
`ifdef COMMUTATOR_RESYNC_EN
        .i_sync(1'b0),
`endif
        .o_branch_data(bdata3), .o_branch_ena(ena3), .o_phase(phase3),
        .o_frame_valid(fv3), .o_primed(primed3)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] e;
        logic       f;
        logic       p;
        logic [1:0] ph;
    } obs_t;

    obs_t        q[$];
    obs_t        got, exp;
    logic [11:0] q3[$];
    logic [11:0] exp3;
    int          n_cmp = 0, n_err = 0;

    logic [1:0] m_phase;
    logic [7:0] m_data;
    logic       m_primed;
    int         m_frames;

    // Drives one cycle; the reference model predicts the outputs seen after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic s);
        obs_t       e;
        logic [1:0] sel;
        @(negedge clk);
        valid = v;
        data  = d;
`ifdef COMMUTATOR_RESYNC_EN
        sync = s;
`endif
        e.e = 4'b0;
        e.f = 1'b0;
        if (v) begin
            sel     = s ? 2'd3 : m_phase;
            e.e     = 4'b0001 << sel;
            e.f     = !s && m_phase == 2'd0;
            m_data  = d;
            m_phase = (sel == 2'd0) ? 2'd3 : sel - 2'd1;
            if (s) begin
                m_frames = 0;
                m_primed = 1'b0;
            end else if (e.f) begin
                if (m_frames < 3) m_frames++;
                if (m_frames == 3) m_primed = 1'b1;
            end
        end
        e.d  = m_data;
        e.p  = m_primed;
        e.ph = m_phase;
        q.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
`ifdef COMMUTATOR_RESYNC_EN
        sync = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b0;
        valid3 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_phase = 2'd3;
        m_data = 8'h00;
        m_primed = 1'b0;
        m_frames = 0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        got = {bdata, ena, fv, primed, phase};
        n_cmp++;
        if (got !== {8'h00, 4'h0, 1'b0, 1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL reset got=%h exp=%h", got, {8'h00, 4'h0, 1'b0, 1'b0, 2'd3});
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0);
            exp = q.pop_front();
            got = {bdata, ena, fv, primed, phase};
            n_cmp++;
            if (got !== exp || ena !== (4'b1000 >> i) || fv !== (i == 3)) begin
                n_err++;
                $display("FAIL basic[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(i % 2 == 0, 8'(8'h30 + i), 1'b0);
            exp = q.pop_front();
            got = {bdata, ena, fv, primed, phase};
            n_cmp++;
            if (got !== exp || (i % 2 == 1 && ena !== 4'b0)) begin
                n_err++;
                $display("FAIL gaps[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_prime();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            exp = q.pop_front();
            got = {bdata, ena, fv, primed, phase};
            n_cmp++;
            if (got !== exp || primed !== (i >= 11)) begin
                n_err++;
                $display("FAIL prime[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        q.delete();
        do_reset();
        got = {bdata, ena, fv, primed, phase};
        n_cmp++;
        if (got !== {8'h00, 4'h0, 1'b0, 1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL midreset_zero got=%h exp=%h", got, {8'h00, 4'h0, 1'b0, 1'b0, 2'd3});
        end
        step(1'b1, 8'h7F, 1'b0);
        exp = q.pop_front();
        got = {bdata, ena, fv, primed, phase};
        n_cmp++;
        if (got !== exp || ena !== 4'b1000 || bdata !== 8'h7F || primed !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_first got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_m3();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid3 = 1'b1;
            data3 = 8'(8'hC0 + i);
            q3.push_back({8'(8'hC0 + i), 3'b100 >> (i % 3), i == 2 || i == 5});
            @(posedge clk);
            #1;
            valid3 = 1'b0;
            exp3 = q3.pop_front();
            n_cmp++;
            if ({bdata3, ena3, fv3} !== exp3 || primed3 !== 1'b0) begin
                n_err++;
                $display("FAIL m3[%0d] got=%h exp=%h primed=%b", i, {bdata3, ena3, fv3}, exp3, primed3);
            end
        end
    endtask

`ifdef COMMUTATOR_RESYNC_EN
    task automatic test_resync();
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 8'(i), 1'b0);
        q.delete();
        n_cmp++;
        if (primed !== 1'b1) begin
            n_err++;
            $display("FAIL resync_pre got=%b exp=1", primed);
        end
        step(1'b1, 8'h55, 1'b1);
        exp = q.pop_front();
        got = {bdata, ena, fv, primed, phase};
        n_cmp++;
        if (got !== exp || ena !== 4'b1000 || bdata !== 8'h55 || fv !== 1'b0 || primed !== 1'b0) begin
            n_err++;
            $display("FAIL resync_hit got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0);
            exp = q.pop_front();
            got = {bdata, ena, fv, primed, phase};
            n_cmp++;
            if (got !== exp || primed !== (i == 10)) begin
                n_err++;
                $display("FAIL resync_reprime[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        valid = 1'b0;
        data = 8'h00;
        valid3 = 1'b0;
        data3 = 8'h00;
`ifdef COMMUTATOR_RESYNC_EN
        sync = 1'b0;
`endif
        test_reset();
        test_basic();
        test_gaps();
        test_prime();
        test_midreset();
        test_m3();
`ifdef COMMUTATOR_RESYNC_EN
        test_resync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
